// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// spi_master_ctrl : full-duplex SPI master with valid/ready request side
// Revision 1.0
// ============================================================================

package globals_pkg;
  parameter int NO_OF_SLAVES = 1;
endpackage

module spi_master_ctrl #(
  parameter int NO_OF_SLAVES = globals_pkg::NO_OF_SLAVES,
  parameter int DATA_WIDTH   = 8,
  parameter int DIV_WIDTH    = 8,
  parameter int SEL_WIDTH    = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1
) (
  input  logic                    pclk,
  input  logic                    areset,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [DATA_WIDTH-1:0]   tx_data,
  input  logic [SEL_WIDTH-1:0]    tx_slave_sel,
  input  logic                    cpol,
  input  logic                    cpha,
  input  logic [DIV_WIDTH-1:0]    baud_div,
  output logic                    rx_valid,
  output logic [DATA_WIDTH-1:0]   rx_data,
  output logic                    err,
  output logic                    busy,
  output logic                    sclk,
  output logic [NO_OF_SLAVES-1:0] cs,
  output logic                    mosi0,
  input  logic                    miso0
);

  localparam int EDGE_W = (DATA_WIDTH > 1) ? $clog2(2 * DATA_WIDTH) : 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_WIDTH-1:0]    div_q, div_d;
  logic [DIV_WIDTH-1:0]    div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic                    cpha_q, cpha_d;
  logic [DATA_WIDTH-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    err_q, err_d;
  logic                    tx_ready_q, tx_ready_d;
  logic                    busy_q, busy_d;
  logic                    sclk_q, sclk_d;
  logic [NO_OF_SLAVES-1:0] cs_q, cs_d;
  logic                    mosi_q, mosi_d;

  logic                    sel_ok;
  logic [NO_OF_SLAVES-1:0] cs_sel;
  logic                    tick;
  logic                    leading;

  always_comb begin
    sel_ok = 1'b0;
    cs_sel = '1;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (int'(tx_slave_sel) == i) begin
        sel_ok    = 1'b1;
        cs_sel[i] = 1'b0;
      end
    end
  end

  assign tick = (div_cnt_q == div_q);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    cpha_d     = cpha_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    err_d      = 1'b0;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    leading    = ~edge_cnt_q[0];

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          if (sel_ok) begin
            state_d    = SETUP;
            div_d      = baud_div;
            cpha_d     = cpha;
            sclk_d     = cpol;
            cs_d       = cs_sel;
            div_cnt_d  = '0;
            edge_cnt_d = '0;
            rx_sr_d    = '0;
            if (!cpha) begin
              mosi_d  = tx_data[DATA_WIDTH-1];
              tx_sr_d = tx_data << 1;
            end else begin
              tx_sr_d = tx_data;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SETUP: begin
        if (tick) begin
          state_d   = SHIFT;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      SHIFT: begin
        if (tick) begin
          div_cnt_d  = '0;
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + 1'b1;
          // Sample edge is leading for cpha=0 and trailing for cpha=1.
          if (leading != cpha_q) begin
            rx_sr_d = DATA_WIDTH'({rx_sr_q, miso0});
          end else if (edge_cnt_q != LAST_EDGE) begin
            mosi_d  = tx_sr_q[DATA_WIDTH-1];
            tx_sr_d = tx_sr_q << 1;
          end
          if (edge_cnt_q == LAST_EDGE) begin
            state_d = HOLD;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (tick) begin
          state_d    = IDLE;
          cs_d       = '1;
          mosi_d     = 1'b0;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sr_q;
          div_cnt_d  = '0;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // A rejected request costs one cycle of tx_ready low while err pulses.
    busy_d     = (state_d != IDLE);
    tx_ready_d = (state_d == IDLE) && !err_d;
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      cpha_q     <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_q       <= '1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      cpha_q     <= cpha_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign sclk     = sclk_q;
  assign cs       = cs_q;
  assign mosi0    = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// tb_spi_master_ctrl: directed and random transfers against a behavioural SPI slave.
module tb_spi_master_ctrl;

  logic       pclk = 1'b0;
  logic       areset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] tx_slave_sel = 3'd0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] baud_div = 8'h00;
  logic       miso0 = 1'b0;
  logic       tx_ready, rx_valid, err, busy, sclk, mosi0;
  logic [7:0] rx_data;
  logic [3:0] cs;

  always #5 pclk = ~pclk;

  spi_master_ctrl #(
    .NO_OF_SLAVES(4), .DATA_WIDTH(8), .DIV_WIDTH(8), .SEL_WIDTH(3)
  ) dut (
    .pclk(pclk), .areset(areset), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_slave_sel(tx_slave_sel), .cpol(cpol), .cpha(cpha),
    .baud_div(baud_div), .rx_valid(rx_valid), .rx_data(rx_data), .err(err),
    .busy(busy), .sclk(sclk), .cs(cs), .mosi0(mosi0), .miso0(miso0)
  );

  int checks = 0;
  int errors = 0;

  // Expected transfer parameters (reference model inputs).
  logic [7:0] exp_data, exp_miso;
  logic       exp_cpol, exp_cpha;
  int         exp_h;
  logic [3:0] exp_cs;
  time        t_acc;

  // Behavioural slave, sampled just after every pclk rising edge.
  logic [7:0] s_word, s_cap;
  int         s_bit = 0, s_edges = 0, sclk_toggles = 0;
  logic       s_cpol, s_cpha, is_lead;
  logic       prev_act = 1'b0, prev_sclk = 1'b0;
  time        t_lead[$];

  always @(posedge pclk) begin
    #1;
    if (sclk !== prev_sclk) sclk_toggles++;
    if (cs != 4'hF) begin
      if (!prev_act) begin
        s_cpol = exp_cpol; s_cpha = exp_cpha; s_word = exp_miso;
        s_cap = 8'h00; s_bit = 0; s_edges = 0; t_lead.delete();
        if (!s_cpha) begin miso0 = s_word[7]; s_bit = 1; end
      end else if (sclk !== prev_sclk) begin
        s_edges++;
        is_lead = (sclk != s_cpol);
        if (is_lead) t_lead.push_back($time);
        if (is_lead ^ s_cpha) s_cap = {s_cap[6:0], mosi0};
        else if (s_bit < 8) begin miso0 = s_word[7 - s_bit]; s_bit++; end
      end
    end
    prev_act  = (cs != 4'hF);
    prev_sclk = sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_exp(input logic [7:0] d, input logic [2:0] sel, input logic pol,
                         input logic pha, input logic [7:0] bd, input logic [7:0] mi);
    exp_data = d; exp_miso = mi; exp_cpol = pol; exp_cpha = pha;
    exp_h    = int'(bd) + 1;
    exp_cs   = 4'hF & ~(4'b0001 << sel);
  endtask

  task automatic start(input logic [7:0] d, input logic [2:0] sel, input logic pol,
                       input logic pha, input logic [7:0] bd, input logic [7:0] mi,
                       input bit hold);
    int n = 0;
    @(negedge pclk);
    set_exp(d, sel, pol, pha, bd, mi);
    tx_valid = 1'b1; tx_data = d; tx_slave_sel = sel;
    cpol = pol; cpha = pha; baud_div = bd;
    while (!tx_ready && n < 1000) begin @(negedge pclk); n++; end
    chk("accept_wait", 32'(tx_ready), 32'd1);
    @(posedge pclk);
    t_acc = $time;
    #2;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic finish(input string tag);
    int n = 0;
    bit ok_busy = 1'b1, ok_cs = 1'b1;
    @(negedge pclk);
    while (!rx_valid && n < 8000) begin
      if (!busy || tx_ready) ok_busy = 1'b0;
      if (cs !== exp_cs) ok_cs = 1'b0;
      @(negedge pclk); n++;
    end
    chk({tag, "_latency"}, 32'(($time - t_acc + 5) / 10), 32'(18 * exp_h + 1));
    chk({tag, "_rx_data"}, 32'(rx_data), 32'(exp_miso));
    chk({tag, "_mosi"}, 32'(s_cap), 32'(exp_data));
    chk({tag, "_edges"}, 32'(s_edges), 32'd16);
    chk({tag, "_period"}, (t_lead.size() >= 2) ? 32'(t_lead[1] - t_lead[0]) : 32'd0,
        32'(20 * exp_h));
    chk({tag, "_sclk_idle"}, 32'(sclk), 32'(exp_cpol));
    chk({tag, "_cs_release"}, 32'(cs), 32'hF);
    chk({tag, "_busy_ready"}, 32'(ok_busy), 32'd1);
    chk({tag, "_cs_select"}, 32'(ok_cs), 32'd1);
  endtask

  task automatic xfer(input logic [7:0] d, input logic [2:0] sel, input logic pol,
                      input logic pha, input logic [7:0] bd, input logic [7:0] mi,
                      input string tag);
    start(d, sel, pol, pha, bd, mi, 1'b0);
    finish(tag);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sclk"}, 32'(sclk), 32'd0);
    chk({tag, "_cs"}, 32'(cs), 32'hF);
    chk({tag, "_mosi"}, 32'(mosi0), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, tog0;
    bit bad;

    // Asynchronous reset, checked before the first pclk edge.
    #2 areset = 1'b0;
    #1 chk_reset("reset");
    repeat (3) @(negedge pclk);
    areset = 1'b1;

    xfer(8'hA5, 3'd0, 1'b0, 1'b0, 8'd0, 8'h3C, "basic");

    for (int m = 0; m < 4; m++)
      xfer(8'h96, 3'd1, m[1], m[0], 8'd3, 8'h69, $sformatf("mode%0d", m));

    xfer(8'h5C, 3'd2, 1'b0, 1'b0, 8'd1, 8'hE7, "sel2");

    // Illegal slave select.
    tog0 = sclk_toggles;
    start(8'h55, 3'd5, 1'b1, 1'b0, 8'd0, 8'h00, 1'b0);
    @(negedge pclk);
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_ready_low", 32'(tx_ready), 32'd0);
    chk("err_cs", 32'(cs), 32'hF);
    @(negedge pclk);
    chk("err_end", 32'(err), 32'd0);
    chk("err_ready_back", 32'(tx_ready), 32'd1);
    bad = 1'b0;
    repeat (20) begin
      @(negedge pclk);
      if (rx_valid || cs !== 4'hF || busy) bad = 1'b1;
    end
    chk("err_quiet", 32'(bad), 32'd0);
    chk("err_no_sclk", 32'(sclk_toggles - tog0), 32'd0);

    // Back-to-back with tx_valid held high.
    start(8'h01, 3'd3, 1'b0, 1'b0, 8'd0, 8'hC4, 1'b1);
    tx_data = 8'h02;
    finish("b2b_first");
    chk("b2b_ready_gap", 32'(tx_ready), 32'd1);
    set_exp(8'h02, 3'd3, 1'b0, 1'b0, 8'd0, 8'h2B);
    @(posedge pclk);
    t_acc = $time;
    #2 tx_valid = 1'b0;
    finish("b2b_second");

    // Inputs change mid-transfer.
    start(8'hC3, 3'd3, 1'b1, 1'b0, 8'd2, 8'h5A, 1'b0);
    repeat (12) @(negedge pclk);
    cpol = 1'b0; cpha = 1'b1; baud_div = 8'd7; tx_data = 8'h00; tx_slave_sel = 3'd0;
    finish("midchg");

    // Randomized transfers.
    for (int r = 0; r < 6; r++)
      xfer(8'($urandom), 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)), 8'($urandom),
           $sformatf("rand%0d", r));

    // Largest divider.
    xfer(8'h81, 3'd0, 1'b1, 1'b1, 8'd255, 8'h7E, "maxdiv");

    // Reset after five SCLK edges.
    start(8'h3E, 3'd2, 1'b0, 1'b1, 8'd1, 8'hB1, 1'b0);
    n = 0;
    while (s_edges < 5 && n < 500) begin @(negedge pclk); n++; end
    chk("rst_edges", 32'(s_edges), 32'd5);
    #2 areset = 1'b0;
    #1 chk_reset("midreset");
    @(negedge pclk);
    areset = 1'b1;
    bad = 1'b0;
    repeat (30) begin
      @(negedge pclk);
      if (rx_valid) bad = 1'b1;
    end
    chk("midreset_no_rx", 32'(bad), 32'd0);

    xfer(8'hFF, 3'd1, 1'b0, 1'b0, 8'd0, 8'h96, "after_reset");

    repeat (4) @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
